// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit core decode stage.
// Contents:
//   - opcode constants (in_ir[15:12])
//   - wb_sel and br encodings
//   - decode FSM state type
//   - the micro-op control bundle carried by the decode output register
//   - sign-extension helpers for the 6- and 9-bit immediates
package isa_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;
  localparam logic [1:0] WB_PC1 = 2'd3;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_JAL  = 2'd2;
  localparam logic [1:0] BR_JLR  = 2'd3;

  // ST_SEQ means more LM/SM micro-ops remain after the one on the output.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  typedef struct packed {
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [2:0] wa;
    logic       we;
    logic       wccr;
    logic       alu_op;
    logic       srcb_imm;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] wb_sel;
    logic [1:0] br;
    logic [1:0] cond;
    logic [2:0] off;
    logic       last;
    logic       illegal;
  } uop_ctrl_t;

  function automatic logic [15:0] sext6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

endpackage

// File: rtl/decode_seq_lmsm_pick.sv
// lmsm_pick: combinational choice of the next LM/SM register index.
// Ports:
//   mask     - registers still to be visited
//   idx      - lowest set index (DESC=0) or highest set index (DESC=1)
//   one_left - exactly one bit is set in mask
//   any      - at least one bit is set in mask
module lmsm_pick #(
  parameter int NREG = 8,
  parameter bit DESC = 1'b0
) (
  input  logic [NREG-1:0] mask,
  output logic [2:0]      idx,
  output logic            one_left,
  output logic            any
);

  // The last matching iteration wins, so the scan direction is the
  // opposite of the priority direction.
  always_comb begin
    idx = '0;
    if (DESC) begin
      for (int i = 0; i < NREG; i++) begin
        if (mask[i]) idx = 3'(i);
      end
    end else begin
      for (int i = NREG - 1; i >= 0; i--) begin
        if (mask[i]) idx = 3'(i);
      end
    end
  end

  assign any      = |mask;
  assign one_left = any && ((mask & (mask - NREG'(1))) == '0);

endmodule

// File: rtl/decode_seq.sv
// decode_seq: registered decode stage between pipe1 and register read.
// Each accepted instruction becomes one micro-op; LM/SM become one micro-op
// per selected register, emitted back to back while fetch is stalled.
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   flush                - kills the presented micro-op and any LM/SM sequence
//   in_valid/in_ready    - pipe1 handshake, in_pc/in_ir instruction payload
//   out_valid/out_ready  - downstream handshake, out_* micro-op payload
//   dbg_state            - current sequencer state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready; while valid && !ready the payload
// holds stable. in_ready is only high in IDLE when the output slot is free
// or being drained this cycle, and never during flush.
module decode_seq
  import isa_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter bit LM_DESC = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [15:0]       in_ir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_ra1,
  output logic [2:0]        out_ra2,
  output logic [2:0]        out_wa,
  output logic              out_we,
  output logic              out_wccr,
  output logic              out_alu_op,
  output logic              out_srcb_imm,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [1:0]        out_wb_sel,
  output logic [1:0]        out_br,
  output logic [1:0]        out_cond,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic [2:0]        out_off,
  output logic              out_last,
  output logic              out_illegal,
  output state_t            dbg_state
);

  state_t            state_q;
  uop_ctrl_t         uop_q;
  uop_ctrl_t         dec;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] dec_imm;
  logic              valid_q;
  logic [NREG-1:0]   mask_q;
  logic [NREG-1:0]   list;
  logic [NREG-1:0]   pick_src;
  logic [NREG-1:0]   pick_bit;
  logic [2:0]        pick_idx;
  logic              pick_one;
  logic              pick_any;
  logic              accept;
  logic              advance;
  logic              is_lmsm;

  assign list = in_ir[NREG-1:0];

  // One picker serves both the first micro-op (from the incoming list)
  // and the following ones (from the shadow mask).
  assign pick_src = (state_q == ST_IDLE) ? list : mask_q;

  lmsm_pick #(
    .NREG (NREG),
    .DESC (LM_DESC)
  ) u_pick (
    .mask     (pick_src),
    .idx      (pick_idx),
    .one_left (pick_one),
    .any      (pick_any)
  );

  assign pick_bit = NREG'(1) << pick_idx;

  assign in_ready = (state_q == ST_IDLE) && (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign advance  = valid_q && out_ready;

  always_comb begin
    dec      = '0;
    dec.last = 1'b1;
    dec_imm  = '0;
    is_lmsm  = 1'b0;
    case (in_ir[15:12])
      OP_ADD, OP_NDU: begin
        dec.ra1    = in_ir[11:9];
        dec.ra2    = in_ir[8:6];
        dec.wa     = in_ir[5:3];
        dec.we     = 1'b1;
        dec.wccr   = 1'b1;
        dec.alu_op = (in_ir[15:12] == OP_NDU);
        dec.cond   = in_ir[1:0];
      end
      OP_ADI: begin
        dec.ra1      = in_ir[11:9];
        dec.wa       = in_ir[8:6];
        dec.srcb_imm = 1'b1;
        dec.we       = 1'b1;
        dec.wccr     = 1'b1;
        dec_imm      = DATA_W'($signed(sext6(in_ir[5:0])));
      end
      OP_LHI: begin
        dec.wa     = in_ir[11:9];
        dec.wb_sel = WB_IMM;
        dec.we     = 1'b1;
        dec_imm    = DATA_W'({in_ir[8:0], 7'b0});
      end
      OP_LW: begin
        dec.wa     = in_ir[11:9];
        dec.ra2    = in_ir[8:6];
        dec.mem_rd = 1'b1;
        dec.wb_sel = WB_MEM;
        dec.we     = 1'b1;
        dec.wccr   = 1'b1;
        dec_imm    = DATA_W'($signed(sext6(in_ir[5:0])));
      end
      OP_SW: begin
        dec.ra1    = in_ir[11:9];
        dec.ra2    = in_ir[8:6];
        dec.mem_wr = 1'b1;
        dec_imm    = DATA_W'($signed(sext6(in_ir[5:0])));
      end
      OP_BEQ: begin
        dec.ra1 = in_ir[11:9];
        dec.ra2 = in_ir[8:6];
        dec.br  = BR_BEQ;
        dec_imm = DATA_W'($signed(sext6(in_ir[5:0])));
      end
      OP_JAL: begin
        dec.wa     = in_ir[11:9];
        dec.wb_sel = WB_PC1;
        dec.we     = 1'b1;
        dec.br     = BR_JAL;
        dec_imm    = DATA_W'($signed(sext9(in_ir[8:0])));
      end
      OP_JLR: begin
        dec.wa     = in_ir[11:9];
        dec.ra2    = in_ir[8:6];
        dec.wb_sel = WB_PC1;
        dec.we     = 1'b1;
        dec.br     = BR_JLR;
      end
      OP_LM, OP_SM: begin
        is_lmsm = 1'b1;
        dec.ra1 = in_ir[11:9];
        // An empty list leaves a single do-nothing micro-op.
        if (pick_any) begin
          dec.last = pick_one;
          if (in_ir[15:12] == OP_LM) begin
            dec.wa     = pick_idx;
            dec.mem_rd = 1'b1;
            dec.wb_sel = WB_MEM;
            dec.we     = 1'b1;
          end else begin
            dec.ra2    = pick_idx;
            dec.mem_wr = 1'b1;
          end
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      valid_q <= 1'b0;
      uop_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      state_q <= ST_IDLE;
      mask_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      uop_q   <= dec;
      imm_q   <= dec_imm;
      pc_q    <= in_pc;
      if (is_lmsm && pick_any && !pick_one) begin
        state_q <= ST_SEQ;
        mask_q  <= list & ~pick_bit;
      end else begin
        mask_q  <= '0;
      end
    end else if (advance) begin
      if (state_q == ST_SEQ) begin
        // Replace the register field in place; base, pc and enables hold.
        mask_q      <= mask_q & ~pick_bit;
        uop_q.off   <= uop_q.off + 3'd1;
        uop_q.last  <= pick_one;
        if (uop_q.mem_rd) uop_q.wa  <= pick_idx;
        else              uop_q.ra2 <= pick_idx;
        // Leave SEQ as soon as the last micro-op is on the output so fetch
        // can be accepted while it drains.
        if (pick_one) state_q <= ST_IDLE;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid    = valid_q;
  assign out_ra1      = uop_q.ra1;
  assign out_ra2      = uop_q.ra2;
  assign out_wa       = uop_q.wa;
  assign out_we       = uop_q.we;
  assign out_wccr     = uop_q.wccr;
  assign out_alu_op   = uop_q.alu_op;
  assign out_srcb_imm = uop_q.srcb_imm;
  assign out_mem_rd   = uop_q.mem_rd;
  assign out_mem_wr   = uop_q.mem_wr;
  assign out_wb_sel   = uop_q.wb_sel;
  assign out_br       = uop_q.br;
  assign out_cond     = uop_q.cond;
  assign out_imm      = imm_q;
  assign out_pc       = pc_q;
  assign out_off      = uop_q.off;
  assign out_last     = uop_q.last;
  assign out_illegal  = uop_q.illegal;
  assign dbg_state    = state_q;

endmodule
